// File: rtl/qdiv_pipe_hs.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per cycle)
// with valid/ready handshakes, divide-by-zero detection, rounding and saturation.
module qdiv_pipe_hs #(
  parameter int N        = 32,
  parameter int Q        = 15,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_overflow,
  output logic         o_div_by_zero
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(N + Q + 1);

  localparam logic [N-1:0] ONE_N   = N'(1);
  localparam logic [N-1:0] MAX_N   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_N   = {1'b1, {(N-1){1'b0}}};
  localparam logic [W:0]   LIM_POS = {{(Q+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W:0]   LIM_NEG = {{(Q+1){1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           ready_q, valid_q, ovf_q, dz_q;
  logic [N-1:0]   quot_q;

  logic signed [N-1:0] a_q, b_q;
  logic                sign_q;
  logic [N-1:0]        bmag_q, rem_q;
  logic [W-1:0]        dvd_q;
  logic [W-2:0]        quo_q;

  logic [N:0]   rem_sh;
  logic [N-1:0] rem_sub, rem_d, dz_quot_d, quot_d;
  logic         ge_d, ovf_d;
  logic [W-1:0] quo_d;
  logic [W:0]   mag_d;

  // Two's complement magnitude; the most negative value maps exactly to 2^(N-1).
  function automatic logic [N-1:0] mag_of(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = v;
    return u[N-1] ? (~u + ONE_N) : u;
  endfunction

  function automatic logic [W:0] round_mag(input logic [W-1:0] q,
                                           input logic [N-1:0] rem,
                                           input logic [N-1:0] div);
    logic up;
    up = (ROUND != 0) && ({rem, 1'b0} >= {1'b0, div});
    return {1'b0, q} + (W+1)'(up);
  endfunction

  // Returns {overflow, signed N-bit result}.
  function automatic logic [N:0] sat_result(input logic [W:0] m, input logic neg);
    logic         ov;
    logic [N-1:0] wrap, res;
    ov   = m > (neg ? LIM_NEG : LIM_POS);
    wrap = neg ? (~m[N-1:0] + ONE_N) : m[N-1:0];
    if (ov && (SATURATE != 0)) res = neg ? MIN_N : MAX_N;
    else                       res = wrap;
    return {ov, res};
  endfunction

  always_comb begin
    rem_sh    = {rem_q, dvd_q[W-1]};
    ge_d      = rem_sh >= {1'b0, bmag_q};
    rem_sub   = rem_sh[N-1:0] - bmag_q;
    rem_d     = ge_d ? rem_sub : rem_sh[N-1:0];
    quo_d     = {quo_q, ge_d};
    mag_d     = round_mag(quo_d, rem_d, bmag_q);
    {ovf_d, quot_d} = sat_result(mag_d, sign_q);
    dz_quot_d = (a_q == '0) ? '0 : (a_q[N-1] ? MIN_N : MAX_N);
  end

  // Datapath registers: no reset, only meaningful while an operation is in flight.
  always_ff @(posedge i_clk) begin
    case (state_q)
      IDLE: if (i_valid) begin
        a_q    <= i_dividend;
        b_q    <= i_divisor;
        sign_q <= i_dividend[N-1] ^ i_divisor[N-1];
      end
      PREP: begin
        bmag_q <= mag_of(b_q);
        dvd_q  <= W'(mag_of(a_q)) << Q;
        quo_q  <= '0;
        rem_q  <= '0;
      end
      ITER: begin
        dvd_q <= dvd_q << 1;
        quo_q <= quo_d[W-2:0];
        rem_q <= rem_d;
      end
      default: ;
    endcase
  end

  // Control and result registers; o_valid lags entry into DONE by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          ready_q <= 1'b0;
          ovf_q   <= 1'b0;
          dz_q    <= 1'b0;
          state_q <= PREP;
        end
        PREP: begin
          cnt_q <= CW'(W - 1);
          if (b_q == '0) begin
            dz_q    <= 1'b1;
            quot_q  <= dz_quot_d;
            state_q <= DONE;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_quotient    = quot_q;
  assign o_overflow    = ovf_q;
  assign o_div_by_zero = dz_q;

endmodule

// File: tb/tb_qdiv_pipe_hs.sv
// Bench for qdiv_pipe_hs: three configurations (trunc/sat, round/sat, trunc/wrap)
// driven in lockstep and checked against an integer-arithmetic reference model.
module tb_qdiv_pipe_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] dvd = '0;
  logic [31:0] dvs = '0;

  logic        rdy [3];
  logic        vld [3];
  logic [31:0] quo [3];
  logic        ovf [3];
  logic        dzf [3];

  bit cfg_rnd [3] = '{1'b0, 1'b1, 1'b0};
  bit cfg_sat [3] = '{1'b1, 1'b1, 1'b0};

  int checks   = 0;
  int failures = 0;

  logic [31:0] cap_q  [3];
  logic        cap_ov [3];
  logic        cap_dz [3];

  always #5 clk = ~clk;

  qdiv_pipe_hs #(.N(32), .Q(15), .ROUND(0), .SATURATE(1)) u_r0s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_dividend(dvd), .i_divisor(dvs), .o_valid(vld[0]), .i_ready(i_ready),
    .o_quotient(quo[0]), .o_overflow(ovf[0]), .o_div_by_zero(dzf[0]));

  qdiv_pipe_hs #(.N(32), .Q(15), .ROUND(1), .SATURATE(1)) u_r1s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_dividend(dvd), .i_divisor(dvs), .o_valid(vld[1]), .i_ready(i_ready),
    .o_quotient(quo[1]), .o_overflow(ovf[1]), .o_div_by_zero(dzf[1]));

  qdiv_pipe_hs #(.N(32), .Q(15), .ROUND(0), .SATURATE(0)) u_r0s0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[2]),
    .i_dividend(dvd), .i_divisor(dvs), .o_valid(vld[2]), .i_ready(i_ready),
    .o_quotient(quo[2]), .o_overflow(ovf[2]), .o_div_by_zero(dzf[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact rational quotient of a*2^15 / b in 64-bit integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit rnd, input bit sat,
                                output logic [31:0] q, output bit ov, output bit dz);
    longint sa, sb, num, den, m, r, lim, sv;
    bit neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    dz = 1'b0;
    if (sb == 0) begin
      dz = 1'b1;
      q  = (sa > 0) ? 32'h7FFFFFFF : ((sa < 0) ? 32'h80000000 : 32'h0);
      return;
    end
    neg = (sa < 0) ^ (sb < 0);
    num = ((sa < 0) ? -sa : sa) * 32768;
    den = (sb < 0) ? -sb : sb;
    m   = num / den;
    r   = num % den;
    if (rnd && (2 * r >= den)) m = m + 1;
    lim = neg ? 64'sd2147483648 : 64'sd2147483647;
    ov  = (m > lim);
    if (ov && sat) q = neg ? 32'h80000000 : 32'h7FFFFFFF;
    else begin
      sv = neg ? -m : m;
      q  = sv[31:0];
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] eq [3];
    bit          eo [3];
    bit          ed [3];
    int          lat;
    int          guard;
    guard = 0;
    while (!rdy[0] && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("ready_before_op", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    dvd = a; dvs = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("ready_low_busy", 64'(rdy[0]), 64'd0);
    lat = 0;
    while (!vld[0] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("latency %h/%h", a, b), 64'(lat), (b == 32'h0) ? 64'd2 : 64'd49);
    for (int k = 0; k < 3; k++) begin
      model(a, b, cfg_rnd[k], cfg_sat[k], eq[k], eo[k], ed[k]);
      chk($sformatf("valid%0d", k), 64'(vld[k]), 64'd1);
      chk($sformatf("quot%0d %h/%h", k, a, b), 64'(quo[k]), 64'(eq[k]));
      chk($sformatf("ovf%0d %h/%h", k, a, b), 64'(ovf[k]), 64'(eo[k]));
      chk($sformatf("dz%0d %h/%h", k, a, b), 64'(dzf[k]), 64'(ed[k]));
      cap_q[k]  = quo[k];
      cap_ov[k] = ovf[k];
      cap_dz[k] = dzf[k];
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      i_valid = 1'($urandom_range(0, 1));
      dvd = $urandom;
      dvs = $urandom;
      @(posedge clk); #1;
      chk("hold_quot", 64'(quo[0]), 64'(eq[0]));
      chk("hold_flags", {62'd0, ovf[0], dzf[0]}, {62'd0, eo[0], ed[0]});
      chk("hold_valid", 64'(vld[0]), 64'd1);
      chk("hold_ready", 64'(rdy[0]), 64'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("valid_drop", 64'(vld[0]), 64'd0);
    chk("ready_rise", 64'(rdy[0]), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), 64'(rdy[k]), 64'd1);
      chk($sformatf("rst_valid%0d", k), 64'(vld[k]), 64'd0);
      chk($sformatf("rst_quot%0d", k), 64'(quo[k]), 64'd0);
      chk($sformatf("rst_flags%0d", k), {62'd0, ovf[k], dzf[k]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h00010000, 32'hFFFE8000, 0);
    chk("dir_2_div_m3", 64'(cap_q[0]), 64'hFFFFAAAB);
    chk("dir_2_div_m3_flags", {62'd0, cap_ov[0], cap_dz[0]}, 64'd0);

    run_op(32'h00008000, 32'h00018000, 1);
    chk("dir_1_div_3_trunc", 64'(cap_q[0]), 64'h00002AAA);
    chk("dir_1_div_3_round", 64'(cap_q[1]), 64'h00002AAB);

    run_op(32'h00008000, 32'h00004000, 0);
    chk("dir_1_div_half_trunc", 64'(cap_q[0]), 64'h00010000);
    chk("dir_1_div_half_round", 64'(cap_q[1]), 64'h00010000);

    run_op(32'h40000000, 32'h00004000, 0);
    chk("dir_ovf_sat", 64'(cap_q[0]), 64'h7FFFFFFF);
    chk("dir_ovf_sat_flag", 64'(cap_ov[0]), 64'd1);

    run_op(32'h80000000, 32'hFFFF8000, 0);
    chk("dir_minneg_sat", 64'(cap_q[0]), 64'h7FFFFFFF);
    chk("dir_minneg_sat_flag", 64'(cap_ov[0]), 64'd1);
    chk("dir_minneg_wrap", 64'(cap_q[2]), 64'h80000000);
    chk("dir_minneg_wrap_flag", 64'(cap_ov[2]), 64'd1);

    run_op(32'hFFFF8000, 32'h00000000, 0);
    chk("dir_dz_neg", 64'(cap_q[0]), 64'h80000000);
    chk("dir_dz_neg_flag", 64'(cap_dz[0]), 64'd1);
    chk("dir_dz_neg_wrapcfg", 64'(cap_q[2]), 64'h80000000);

    run_op(32'h00000000, 32'h00000000, 0);
    chk("dir_dz_zero", 64'(cap_q[0]), 64'h0);
    chk("dir_dz_zero_flag", 64'(cap_dz[0]), 64'd1);

    run_op(32'h00050000, 32'h00020000, 10);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 32'h0003FFFF);
        2: rb = 32'h0 - $urandom_range(1, 32'h0003FFFF);
        3: rb = 32'h0;
        default: begin
          ra = ra >>> $urandom_range(8, 24);
          rb = $urandom_range(1, 32'h000FFFFF);
        end
      endcase
      run_op(ra, rb, $urandom_range(0, 3));
    end

    @(negedge clk);
    dvd = 32'h12345678; dvs = 32'h00018000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (27) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_valid%0d", k), 64'(vld[k]), 64'd0);
      chk($sformatf("midrst_ready%0d", k), 64'(rdy[k]), 64'd1);
      chk($sformatf("midrst_quot%0d", k), 64'(quo[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h00030000, 32'h00010000, 0);
    chk("dir_6_div_2", 64'(cap_q[0]), 64'h00018000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
